// File: rtl/sr_imem_loader_pkg.sv
// Shared loader state encodings and the RISC-V NOP returned for unmapped fetches.
// Imported by the loader top and its testbench-facing interface users.
package sr_imem_loader_pkg;

  typedef enum logic [1:0] {
    LDR_LEN0 = 2'd0,
    LDR_LEN1 = 2'd1,
    LDR_DATA = 2'd2,
    LDR_DONE = 2'd3
  } ldrState_t;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/sr_imem_loader_if.sv
// Byte-stream load channel: source drives rxValid/rxData, loader answers rxReady.
// A byte moves on a rising edge where rxValid && rxReady.
interface sr_imem_loader_if;
  logic       rxValid;
  logic [7:0] rxData;
  logic       rxReady;

  modport master (output rxValid, output rxData, input rxReady);
  modport slave  (input rxValid, input rxData, output rxReady);
endinterface

// File: rtl/sr_imem.sv
// Word memory: synchronous write, asynchronous read, no reset (contents survive rst_n).
// Read returns the old word until the write edge; no backpressure.
module sr_imem #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wAddr,
  input  logic [31:0]           wData,
  input  logic [ADDR_WIDTH-1:0] rAddr,
  output logic [31:0]           rData
);

  logic [31:0] mem [1<<ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[wAddr] <= wData;
  end

  assign rData = mem[rAddr];

endmodule

// File: rtl/sr_imem_loader.sv
// Instruction memory with little-endian byte-stream loader; holds the core in reset while loading.
// Word written on its 4th byte edge, fetch is combinational; rxReady drops only in DONE.
module sr_imem_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  sr_imem_loader_if.slave    rx,
  input  logic               reload,
  input  logic [31:0]        imAddr,
  output logic [31:0]        imData,
  output logic               cpuRstN,
  output logic               busy
);
  import sr_imem_loader_pkg::*;

  ldrState_t   state;
  logic [15:0] wordCnt;
  logic [15:0] wordIdx;
  logic [1:0]  byteIdx;
  logic [7:0]  b0, b1, b2;

  logic        accept;
  logic        lastByte;
  logic        wordInRange;
  logic        memWe;
  logic [31:0] memRdata;

  assign rx.rxReady  = (state != LDR_DONE);
  assign accept      = rx.rxValid && rx.rxReady;
  assign lastByte    = (byteIdx == 2'd3);
  // Words past the end of memory are still counted so N is honoured, but never stored.
  assign wordInRange = ((wordIdx >> ADDR_WIDTH) == 16'd0);
  assign memWe       = accept && !reload && (state == LDR_DATA) && lastByte && wordInRange;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LDR_LEN0;
      wordCnt <= 16'd0;
      wordIdx <= 16'd0;
      byteIdx <= 2'd0;
      b0      <= 8'd0;
      b1      <= 8'd0;
      b2      <= 8'd0;
      cpuRstN <= 1'b0;
      busy    <= 1'b1;
    end else if (reload) begin
      state   <= LDR_LEN0;
      wordIdx <= 16'd0;
      byteIdx <= 2'd0;
      cpuRstN <= 1'b0;
      busy    <= 1'b1;
    end else if (accept) begin
      case (state)
        LDR_LEN0: begin
          wordCnt[7:0] <= rx.rxData;
          state        <= LDR_LEN1;
        end
        LDR_LEN1: begin
          wordCnt[15:8] <= rx.rxData;
          if ({rx.rxData, wordCnt[7:0]} == 16'd0) begin
            state   <= LDR_DONE;
            cpuRstN <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state <= LDR_DATA;
          end
        end
        LDR_DATA: begin
          case (byteIdx)
            2'd0:    b0 <= rx.rxData;
            2'd1:    b1 <= rx.rxData;
            2'd2:    b2 <= rx.rxData;
            default: ;
          endcase
          byteIdx <= byteIdx + 2'd1;
          if (lastByte) begin
            wordIdx <= wordIdx + 16'd1;
            if (wordIdx == wordCnt - 16'd1) begin
              state   <= LDR_DONE;
              cpuRstN <= 1'b1;
              busy    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  sr_imem #(.ADDR_WIDTH(ADDR_WIDTH)) u_imem (
    .clk   (clk),
    .we    (memWe),
    .wAddr (wordIdx[ADDR_WIDTH-1:0]),
    .wData ({rx.rxData, b2, b1, b0}),
    .rAddr (imAddr[ADDR_WIDTH-1:0]),
    .rData (memRdata)
  );

  assign imData = ((imAddr >> ADDR_WIDTH) == 32'd0) ? memRdata : RV_NOP;

endmodule

// File: tb/tb_sr_imem_loader.sv
// Directed bench: default-depth loader plus a 4-word instance for the overflow case.
module tb_sr_imem_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sr_imem_loader_if ifA ();
  sr_imem_loader_if ifB ();

  logic        reloadA, reloadB;
  logic [31:0] imAddrA, imAddrB, imDataA, imDataB;
  logic        cpuRstNA, cpuRstNB, busyA, busyB;

  int errors = 0;
  int checks = 0;

  sr_imem_loader #(.ADDR_WIDTH(6)) dutA (
    .clk(clk), .rst_n(rst_n), .rx(ifA.slave), .reload(reloadA),
    .imAddr(imAddrA), .imData(imDataA), .cpuRstN(cpuRstNA), .busy(busyA)
  );

  sr_imem_loader #(.ADDR_WIDTH(2)) dutB (
    .clk(clk), .rst_n(rst_n), .rx(ifB.slave), .reload(reloadB),
    .imAddr(imAddrB), .imData(imDataB), .cpuRstN(cpuRstNB), .busy(busyB)
  );

  task automatic sendA(input logic [7:0] b, input int gap);
    ifA.rxValid = 1'b1;
    ifA.rxData  = b;
    @(posedge clk); #1;
    ifA.rxValid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic sendB(input logic [7:0] b);
    ifB.rxValid = 1'b1;
    ifB.rxData  = b;
    @(posedge clk); #1;
    ifB.rxValid = 1'b0;
  endtask

  task automatic pulseReloadA(input logic withByte, input logic [7:0] b);
    reloadA = 1'b1;
    ifA.rxValid = withByte;
    ifA.rxData  = b;
    @(posedge clk); #1;
    reloadA = 1'b0;
    ifA.rxValid = 1'b0;
  endtask

  task automatic rdA(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    imAddrA = a;
    #1 d = imDataA;
  endtask

  task automatic rdB(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    imAddrB = a;
    #1 d = imDataB;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (cpuRstNA !== 1'b0) begin errors++; $display("FAIL reset_cpuRstN got=%b exp=0", cpuRstNA); end
    checks++; if (ifA.rxReady !== 1'b1) begin errors++; $display("FAIL reset_rxReady got=%b exp=1", ifA.rxReady); end
    checks++; if (busyA !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busyA); end
    checks++; if (cpuRstNB !== 1'b0 || busyB !== 1'b1) begin errors++; $display("FAIL reset_B got=%b/%b exp=0/1", cpuRstNB, busyB); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0]  img [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    logic [31:0] d;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        checks++; if (cpuRstNA !== 1'b0) begin errors++; $display("FAIL basic_hold got=%b exp=0", cpuRstNA); end
      end
      sendA(img[i], 0);
    end
    checks++; if (cpuRstNA !== 1'b1) begin errors++; $display("FAIL basic_release got=%b exp=1", cpuRstNA); end
    checks++; if (ifA.rxReady !== 1'b0 || busyA !== 1'b0) begin errors++; $display("FAIL basic_done got=%b/%b exp=0/0", ifA.rxReady, busyA); end
    rdA(32'd0, d);
    checks++; if (d !== 32'h0010_0513) begin errors++; $display("FAIL basic_mem0 got=%h exp=00100513", d); end
    rdA(32'd1, d);
    checks++; if (d !== 32'h0020_0593) begin errors++; $display("FAIL basic_mem1 got=%h exp=00200593", d); end
    rdA(32'd64, d);
    checks++; if (d !== 32'h0000_0013) begin errors++; $display("FAIL basic_oor64 got=%h exp=00000013", d); end
    rdA(32'h8000_0001, d);
    checks++; if (d !== 32'h0000_0013) begin errors++; $display("FAIL basic_oorhi got=%h exp=00000013", d); end
  endtask

  task automatic test_gapped();
    logic [7:0]  img [10] = '{8'h02, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};
    logic [31:0] d;
    pulseReloadA(1'b0, 8'h00);
    checks++; if (cpuRstNA !== 1'b0 || ifA.rxReady !== 1'b1) begin errors++; $display("FAIL gap_reload got=%b/%b exp=0/1", cpuRstNA, ifA.rxReady); end
    imAddrA = 32'd0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        #1;
        checks++; if (imDataA !== 32'h0010_0513) begin errors++; $display("FAIL gap_oldword got=%h exp=00100513", imDataA); end
      end
      if (i == 9) begin
        checks++; if (cpuRstNA !== 1'b0) begin errors++; $display("FAIL gap_hold got=%b exp=0", cpuRstNA); end
      end
      sendA(img[i], 1);
      if (i == 5) begin
        checks++; if (imDataA !== 32'hAABB_CCDD) begin errors++; $display("FAIL gap_newword got=%h exp=aabbccdd", imDataA); end
      end
    end
    checks++; if (cpuRstNA !== 1'b1) begin errors++; $display("FAIL gap_release got=%b exp=1", cpuRstNA); end
    rdA(32'd1, d);
    checks++; if (d !== 32'h1122_3344) begin errors++; $display("FAIL gap_mem1 got=%h exp=11223344", d); end
  endtask

  task automatic test_reload();
    logic [31:0] d;
    pulseReloadA(1'b1, 8'h07);
    checks++; if (cpuRstNA !== 1'b0 || ifA.rxReady !== 1'b1 || busyA !== 1'b1) begin
      errors++; $display("FAIL reload_state got=%b/%b/%b exp=0/1/1", cpuRstNA, ifA.rxReady, busyA); end
    // Second reload with a live byte: if the byte leaked in, N would become 0x0107.
    pulseReloadA(1'b1, 8'h07);
    sendA(8'h01, 0); sendA(8'h00, 0);
    sendA(8'hEF, 0); sendA(8'hBE, 0); sendA(8'hAD, 0); sendA(8'hDE, 0);
    checks++; if (cpuRstNA !== 1'b1) begin errors++; $display("FAIL reload_release got=%b exp=1", cpuRstNA); end
    rdA(32'd0, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reload_mem0 got=%h exp=deadbeef", d); end
    rdA(32'd1, d);
    checks++; if (d !== 32'h1122_3344) begin errors++; $display("FAIL reload_mem1 got=%h exp=11223344", d); end
  endtask

  task automatic test_zero();
    logic [31:0] d;
    pulseReloadA(1'b0, 8'h00);
    sendA(8'h00, 0);
    checks++; if (cpuRstNA !== 1'b0 || busyA !== 1'b1) begin errors++; $display("FAIL zero_first got=%b/%b exp=0/1", cpuRstNA, busyA); end
    sendA(8'h00, 0);
    checks++; if (cpuRstNA !== 1'b1 || ifA.rxReady !== 1'b0) begin errors++; $display("FAIL zero_done got=%b/%b exp=1/0", cpuRstNA, ifA.rxReady); end
    rdA(32'd0, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zero_mem0 got=%h exp=deadbeef", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] w [5] = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004, 32'hFFFF_FFFF};
    logic [31:0] d;
    logic [31:0] cur;
    sendB(8'h05); sendB(8'h00);
    for (int k = 0; k < 5; k++) begin
      cur = w[k];
      for (int j = 0; j < 4; j++) begin
        if (k == 4 && j == 3) begin
          checks++; if (cpuRstNB !== 1'b0) begin errors++; $display("FAIL ovf_hold got=%b exp=0", cpuRstNB); end
        end
        sendB(cur[8*j +: 8]);
      end
    end
    checks++; if (cpuRstNB !== 1'b1 || busyB !== 1'b0) begin errors++; $display("FAIL ovf_release got=%b/%b exp=1/0", cpuRstNB, busyB); end
    for (int a = 0; a < 4; a++) begin
      rdB(a, d);
      checks++; if (d !== w[a]) begin errors++; $display("FAIL ovf_mem%0d got=%h exp=%h", a, d, w[a]); end
    end
    rdB(32'd4, d);
    checks++; if (d !== 32'h0000_0013) begin errors++; $display("FAIL ovf_oor4 got=%h exp=00000013", d); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    pulseReloadA(1'b0, 8'h00);
    sendA(8'h02, 0); sendA(8'h00, 0);
    sendA(8'h0D, 0); sendA(8'h0C, 0); sendA(8'h0B, 0); sendA(8'h0A, 0);
    sendA(8'h55, 0); sendA(8'h66, 0);
    rst_n = 1'b0;
    #1;
    checks++; if (cpuRstNA !== 1'b0 || ifA.rxReady !== 1'b1 || busyA !== 1'b1) begin
      errors++; $display("FAIL arst_outputs got=%b/%b/%b exp=0/1/1", cpuRstNA, ifA.rxReady, busyA); end
    rdA(32'd0, d);
    checks++; if (d !== 32'h0A0B_0C0D) begin errors++; $display("FAIL arst_mem0 got=%h exp=0a0b0c0d", d); end
    rdA(32'd1, d);
    checks++; if (d !== 32'h1122_3344) begin errors++; $display("FAIL arst_mem1 got=%h exp=11223344", d); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    sendA(8'h01, 0); sendA(8'h00, 0);
    sendA(8'h78, 0); sendA(8'h56, 0); sendA(8'h34, 0); sendA(8'h12, 0);
    checks++; if (cpuRstNA !== 1'b1) begin errors++; $display("FAIL arst_reload_release got=%b exp=1", cpuRstNA); end
    rdA(32'd0, d);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL arst_mem0_new got=%h exp=12345678", d); end
  endtask

  initial begin
    ifA.rxValid = 1'b0; ifA.rxData = 8'h00;
    ifB.rxValid = 1'b0; ifB.rxData = 8'h00;
    reloadA = 1'b0; reloadB = 1'b0;
    imAddrA = 32'd0; imAddrB = 32'd0;
    test_reset();
    test_basic();
    test_gapped();
    test_reload();
    test_zero();
    test_overflow();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
